// File: rtl/esn7e_st_snk_pkg.sv
// Shared field positions, rail constants and the word-unpack helper for the ESN estimate sink.
// The sample record is what the registered output stage carries for each word.
package esn7e_st_snk_pkg;

    localparam int U_MSB = 31;
    localparam int U_LSB = 16;
    localparam int Y_MSB = 15;
    localparam int Y_LSB = 0;

    // ASCII-safe form: four bytes {1'b0, 7 payload bits}; byte n starts at bit ASC_Bn.
    localparam int ASC_B3   = 24;
    localparam int ASC_B2   = 16;
    localparam int ASC_B1   = 8;
    localparam int ASC_B0   = 0;
    localparam int ASC_FLAG = 7;

    localparam int YHAT_EXT = 6;
    localparam int YHAT_PAD = 10;

    localparam logic [15:0] Y_RAIL_POS = 16'h7FFF;
    localparam logic [15:0] Y_RAIL_NEG = 16'h8000;
    localparam logic [15:0] DROP_MAX   = 16'hFFFF;

    typedef struct packed {
        logic [15:0] u;
        logic [31:0] yhat;
        logic        sat;
        logic        fmt_err;
    } sample_t;

    function automatic sample_t unpack_word(input logic [31:0] w, input logic ascii);
        sample_t     s;
        logic [15:0] y16;
        if (ascii) begin
            s.u       = {w[ASC_B3 +: 7], w[ASC_B2 +: 7], 2'b00};
            y16       = {w[ASC_B1 +: 7], w[ASC_B0 +: 7], 2'b00};
            s.fmt_err = w[ASC_B3 + ASC_FLAG] | w[ASC_B2 + ASC_FLAG]
                      | w[ASC_B1 + ASC_FLAG] | w[ASC_B0 + ASC_FLAG];
        end else begin
            s.u       = w[U_MSB:U_LSB];
            y16       = w[Y_MSB:Y_LSB];
            s.fmt_err = 1'b0;
        end
        // Q4.11 -> Q10.21: six sign bits on top, ten zero fraction bits below.
        s.yhat = {{YHAT_EXT{y16[15]}}, y16, {YHAT_PAD{1'b0}}};
        s.sat  = (y16 == Y_RAIL_POS) || (y16 == Y_RAIL_NEG);
        return s;
    endfunction

endpackage

// File: rtl/esn7e_st_snk_fifo.sv
// Word FIFO for the estimate sink. A word leaves the FIFO only when the consumer takes it,
// and rd_data/empty describe the head as it will be after this cycle's pop.
module esn7e_st_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2:0] ptr_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    ptr_t             wr_ptr_q;
    ptr_t             wr_ptr_d;
    ptr_t             rd_ptr_q;
    ptr_t             rd_ptr_d;
    ptr_t             wr_vis_q;

    assign wr_ptr_d = wr_ptr_q + ptr_t'(wr_en);
    assign rd_ptr_d = rd_ptr_q + ptr_t'(rd_en);

    // wr_vis_q trails the write pointer by a cycle, so a new word reaches the reader one cycle late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_vis_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_vis_q <= wr_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // full is the post-update state so the registered ready in the top closes on the right edge.
    assign full    = (wr_ptr_d[DEPTH_LOG2] != rd_ptr_d[DEPTH_LOG2])
                  && (wr_ptr_d[DEPTH_LOG2-1:0] == rd_ptr_d[DEPTH_LOG2-1:0]);
    assign empty   = (wr_vis_q == rd_ptr_d);
    assign rd_data = mem_q[rd_ptr_d[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/esn7e_st_snk.sv
// Avalon-ST sink for the ESN estimate stream: buffers packed words, unpacks and re-expands
// the estimate to Q10.21, flags rail values and counts words dropped while the FIFO is full.
module esn7e_st_snk
    import esn7e_st_snk_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int ASCII_MODE = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data_valid,
    input  logic [31:0] data_in,
    output logic        data_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] u_out,
    output logic [31:0] yhat_out,
    output logic        yhat_sat,
    output logic        fmt_err,
    output logic [15:0] drop_cnt
);
    logic        data_ready_q;
    logic        out_valid_q;
    logic        out_valid_d;
    sample_t     sample_q;
    sample_t     sample_d;
    sample_t     head;
    logic [15:0] drop_cnt_q;
    logic [15:0] drop_cnt_d;
    logic        pop;
    logic        accept;
    logic        drop;
    logic        load_en;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_rd_data;

    // A pop in the same cycle frees the slot, so a full FIFO still takes the word.
    assign pop     = out_valid_q & out_ready;
    assign accept  = data_valid & (data_ready_q | pop);
    assign drop    = data_valid & ~accept;
    assign load_en = ~out_valid_q | out_ready;

    esn7e_st_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .wr_en   (accept),
        .wr_data (data_in),
        .rd_en   (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .rd_data (fifo_rd_data)
    );

    assign head = unpack_word(fifo_rd_data, ASCII_MODE != 0);

    always_comb begin
        out_valid_d = out_valid_q;
        sample_d    = sample_q;
        drop_cnt_d  = drop_cnt_q;
        if (load_en) begin
            out_valid_d = ~fifo_empty;
            if (!fifo_empty) begin
                sample_d = head;
            end
        end
        if (drop && (drop_cnt_q != DROP_MAX)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            sample_q     <= '0;
            drop_cnt_q   <= '0;
        end else begin
            data_ready_q <= ~fifo_full;
            out_valid_q  <= out_valid_d;
            sample_q     <= sample_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign data_ready = data_ready_q;
    assign out_valid  = out_valid_q;
    assign u_out      = sample_q.u;
    assign yhat_out   = sample_q.yhat;
    assign yhat_sat   = sample_q.sat;
    assign fmt_err    = sample_q.fmt_err;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_esn7e_st_snk.sv
// Self-checking bench for esn7e_st_snk: directed raw/ASCII/full/reset steps plus a randomized
// backpressure run, all compared against an arithmetic reference model of the unpack rules.
module tb_esn7e_st_snk;

    typedef struct packed {
        logic [15:0] u;
        logic [31:0] y;
        logic        sat;
        logic        fe;
    } expT;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        dataValid;
    logic [31:0] dataIn;
    logic        dataReady;
    logic        outValid;
    logic        outReady;
    logic [15:0] uOut;
    logic [31:0] yhatOut;
    logic        yhatSat;
    logic        fmtErr;
    logic [15:0] dropCnt;

    logic        aValid;
    logic [31:0] aData;
    logic        aReady;
    logic        aOutValid;
    logic        aOutReady;
    logic [15:0] aU;
    logic [31:0] aYhat;
    logic        aSat;
    logic        aFmt;
    logic [15:0] aDrop;

    int checks = 0;
    int errors = 0;
    expT expQ[$];

    always #5 clk = ~clk;

    esn7e_st_snk #(.DEPTH_LOG2(3), .ASCII_MODE(0)) dutRaw (
        .clk(clk), .reset_n(reset_n), .data_valid(dataValid), .data_in(dataIn),
        .data_ready(dataReady), .out_valid(outValid), .out_ready(outReady),
        .u_out(uOut), .yhat_out(yhatOut), .yhat_sat(yhatSat), .fmt_err(fmtErr),
        .drop_cnt(dropCnt)
    );

    esn7e_st_snk #(.DEPTH_LOG2(3), .ASCII_MODE(1)) dutAsc (
        .clk(clk), .reset_n(reset_n), .data_valid(aValid), .data_in(aData),
        .data_ready(aReady), .out_valid(aOutValid), .out_ready(aOutReady),
        .u_out(aU), .yhat_out(aYhat), .yhat_sat(aSat), .fmt_err(aFmt),
        .drop_cnt(aDrop)
    );

    // Reference: plain arithmetic on the word, estimate scaled by 2**10 as a signed integer.
    function automatic expT refModel(input logic [31:0] w, input bit ascii);
        expT         r;
        logic [15:0] y16;
        if (ascii) begin
            r.u  = 16'((((w >> 24) & 32'h7F) * 32'd512) + (((w >> 16) & 32'h7F) * 32'd4));
            y16  = 16'((((w >> 8) & 32'h7F) * 32'd512) + ((w & 32'h7F) * 32'd4));
            r.fe = ((w & 32'h8080_8080) != 32'd0);
        end else begin
            r.u  = 16'(w / 32'd65536);
            y16  = 16'(w % 32'd65536);
            r.fe = 1'b0;
        end
        r.y   = 32'($signed(y16) * 1024);
        r.sat = (y16 == 16'd32767) || (y16 == 16'd32768);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic ready);
        dataValid = valid;
        dataIn    = data;
        outReady  = ready;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        expT         e;
        expT         held;
        logic [31:0] w [10];
        logic [31:0] word;
        logic        sendNow;
        logic        willPop;
        logic        stalled;
        int          sent;
        int          received;

        // Reset state
        reset_n   = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0);
        aValid    = 1'b0;
        aData     = 32'd0;
        aOutReady = 1'b1;
        #12;
        checkOutput("rstReady", 32'(dataReady), 32'd0);
        checkOutput("rstValid", 32'(outValid), 32'd0);
        checkOutput("rstDrop", 32'(dropCnt), 32'd0);
        checkOutput("rstU", 32'(uOut), 32'd0);
        checkOutput("rstYhat", yhatOut, 32'd0);
        checkOutput("rstSat", 32'(yhatSat), 32'd0);
        tick();
        reset_n = 1'b1;
        checkOutput("readyLowBeforeEdge", 32'(dataReady), 32'd0);
        tick();
        checkOutput("readyAfterReset", 32'(dataReady), 32'd1);

        // Raw word, latency of two edges
        applyStimulus(1'b1, 32'h1000_0800, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("t1Lat0", 32'(outValid), 32'd0);
        tick();
        checkOutput("t1Lat1", 32'(outValid), 32'd0);
        tick();
        checkOutput("t1Valid", 32'(outValid), 32'd1);
        checkOutput("t1U", 32'(uOut), 32'h0000_1000);
        checkOutput("t1Yhat", yhatOut, 32'h0020_0000);
        checkOutput("t1Sat", 32'(yhatSat), 32'd0);
        checkOutput("t1Fmt", 32'(fmtErr), 32'd0);
        tick();
        checkOutput("t1Consumed", 32'(outValid), 32'd0);

        // Rail values, back to back
        applyStimulus(1'b1, 32'h1234_8000, 1'b1);
        tick();
        applyStimulus(1'b1, 32'hABCD_7FFF, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1);
        tick();
        checkOutput("t2NegValid", 32'(outValid), 32'd1);
        checkOutput("t2NegU", 32'(uOut), 32'h0000_1234);
        checkOutput("t2NegYhat", yhatOut, 32'hFE00_0000);
        checkOutput("t2NegSat", 32'(yhatSat), 32'd1);
        tick();
        checkOutput("t2PosValid", 32'(outValid), 32'd1);
        checkOutput("t2PosU", 32'(uOut), 32'h0000_ABCD);
        checkOutput("t2PosYhat", yhatOut, 32'h01FF_FC00);
        checkOutput("t2PosSat", 32'(yhatSat), 32'd1);
        tick();
        checkOutput("t2Drained", 32'(outValid), 32'd0);

        // Fill and drop: ten words into an eight-deep FIFO with the consumer stalled
        for (int i = 0; i < 10; i++) begin
            w[i] = $urandom;
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, w[i], 1'b0);
            tick();
            checkOutput($sformatf("t3Ready%0d", i), 32'(dataReady), (i + 1 < 8) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 32'd0, 1'b0);
        checkOutput("t3DropCnt", 32'(dropCnt), 32'd2);
        outReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e = refModel(w[k], 1'b0);
            checkOutput($sformatf("t3Valid%0d", k), 32'(outValid), 32'd1);
            checkOutput($sformatf("t3U%0d", k), 32'(uOut), 32'(e.u));
            checkOutput($sformatf("t3Yhat%0d", k), yhatOut, e.y);
            tick();
            if (k == 0) begin
                checkOutput("t3ReadyReopen", 32'(dataReady), 32'd1);
            end
        end
        checkOutput("t3Empty", 32'(outValid), 32'd0);

        // ASCII decode on the second instance
        aValid = 1'b1;
        aData  = 32'h0810_0408;
        tick();
        aData  = 32'h8810_0408;
        tick();
        aValid = 1'b0;
        tick();
        checkOutput("t4Valid", 32'(aOutValid), 32'd1);
        checkOutput("t4U", 32'(aU), 32'h0000_1040);
        checkOutput("t4Yhat", aYhat, 32'h0020_8000);
        checkOutput("t4Fmt0", 32'(aFmt), 32'd0);
        checkOutput("t4Sat", 32'(aSat), 32'd0);
        tick();
        checkOutput("t4U2", 32'(aU), 32'h0000_1040);
        checkOutput("t4Fmt1", 32'(aFmt), 32'd1);

        // Randomized backpressure over 100 words
        sent     = 0;
        received = 0;
        stalled  = 1'b0;
        held     = '0;
        expQ.delete();
        for (int cyc = 0; cyc < 3000 && received < 100; cyc++) begin
            if (stalled) begin
                checkOutput("t5StallValid", 32'(outValid), 32'd1);
                checkOutput("t5StallU", 32'(uOut), 32'(held.u));
                checkOutput("t5StallYhat", yhatOut, held.y);
                checkOutput("t5StallSat", 32'(yhatSat), 32'(held.sat));
            end
            word    = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                word[15:0] = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
            end
            sendNow = (sent < 100) && dataReady && ($urandom_range(0, 3) != 0);
            applyStimulus(sendNow, word, $urandom_range(0, 1) == 1);
            willPop = outValid && outReady;
            stalled = outValid && !outReady;
            held    = '{u: uOut, y: yhatOut, sat: yhatSat, fe: fmtErr};
            if (willPop) begin
                if (expQ.size() == 0) begin
                    checkOutput("t5Unexpected", 32'(outValid), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("t5U", 32'(uOut), 32'(e.u));
                    checkOutput("t5Yhat", yhatOut, e.y);
                    checkOutput("t5Sat", 32'(yhatSat), 32'(e.sat));
                end
                received++;
            end
            if (sendNow) begin
                expQ.push_back(refModel(word, 1'b0));
                sent++;
            end
            tick();
        end
        applyStimulus(1'b0, 32'd0, 1'b0);
        checkOutput("t5Received", 32'(received), 32'd100);
        checkOutput("t5QueueEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("t5DropUnchanged", 32'(dropCnt), 32'd2);

        // Reset pulse with the FIFO half full
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, $urandom, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'd0, 1'b0);
        tick();
        tick();
        checkOutput("t6ValidBefore", 32'(outValid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6ValidAsync", 32'(outValid), 32'd0);
        checkOutput("t6DropAsync", 32'(dropCnt), 32'd0);
        checkOutput("t6ReadyAsync", 32'(dataReady), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        checkOutput("t6ReadyAgain", 32'(dataReady), 32'd1);
        word = 32'h5A5A_C3C3;
        e    = refModel(word, 1'b0);
        applyStimulus(1'b1, word, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("t6Lat0", 32'(outValid), 32'd0);
        tick();
        checkOutput("t6Lat1", 32'(outValid), 32'd0);
        tick();
        checkOutput("t6Valid", 32'(outValid), 32'd1);
        checkOutput("t6U", 32'(uOut), 32'(e.u));
        checkOutput("t6Yhat", yhatOut, e.y);
        checkOutput("t6Sat", 32'(yhatSat), 32'(e.sat));
        tick();
        checkOutput("t6NoStale", 32'(outValid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
